inst_enc: RTL and testbench

//  RV32I instruction encoder, inverse of the core's instruction decoder: accepts field-level

---
 rtl/inst_enc.sv | 180 ++++++++++++++++++
 tb/tb_inst_enc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_enc.sv
// RV32I instruction encoder for the boot/debug loader. Packs field-level requests into
// 32-bit words, buffers them, and streams them into imem at an auto-incrementing address.
module inst_enc #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  addr_clr,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_type,
   input  logic [2:0]            req_funct3,
   input  logic                  req_alt,
   input  logic [4:0]            req_rd,
   input  logic [4:0]            req_rs1,
   input  logic [4:0]            req_rs2,
   input  logic [31:0]           req_imm,
   output logic                  imem_wen,
   input  logic                  imem_wready,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]           imem_wdata,
   output logic                  enc_err,
   output logic [7:0]            err_cnt,
   output logic [ADDR_WIDTH:0]   wr_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [PW:0]           DEPTH_C = (PW+1)'(FIFO_DEPTH);

   localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_IL = 4'd2, T_S = 4'd3, T_B = 4'd4,
                          T_JAL = 4'd5, T_JALR = 4'd6, T_LUI = 4'd7, T_AUIPC = 4'd8;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_IL = 7'b0000011,
                          OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   logic [31:0]           mem_q [FIFO_DEPTH];
   logic [31:0]           mem_d [FIFO_DEPTH];
   logic [PW:0]           count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  enc_err_q, enc_err_d;

   logic [31:0] word;
   logic        legal;
   logic        fits12, fits13, fits21;
   logic [6:0]  funct7;
   logic        accept, push, pop;

   // Signed range checks: value fits when all bits above the field's sign bit agree.
   always_comb begin
      fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
      fits13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
      fits21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);
      funct7 = {1'b0, req_alt, 5'b00000};
      word   = '0;
      legal  = 1'b1;
      case (req_type)
         T_R: begin
            word  = {funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
            legal = ~req_alt | (req_funct3 == 3'b000) | (req_funct3 == 3'b101);
         end
         T_I: begin
            if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
               word  = {funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I};
               legal = ~(|req_imm[31:5]) & (~req_alt | (req_funct3 == 3'b101));
            end else begin
               word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
               legal = fits12;
            end
         end
         T_IL: begin
            word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IL};
            legal = fits12 & (req_funct3 != 3'b011) & (req_funct3 != 3'b110)
                    & (req_funct3 != 3'b111);
         end
         T_S: begin
            word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_S};
            legal = fits12 & (req_funct3 <= 3'b010);
         end
         T_B: begin
            word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                     req_imm[4:1], req_imm[11], OP_B};
            legal = fits13 & ~req_imm[0] & (req_funct3 != 3'b010) & (req_funct3 != 3'b011);
         end
         T_JAL: begin
            word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            legal = fits21 & ~req_imm[0];
         end
         T_JALR: begin
            word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            legal = fits12;
         end
         T_LUI: begin
            word  = {req_imm[31:12], req_rd, OP_LUI};
            legal = ~(|req_imm[11:0]);
         end
         T_AUIPC: begin
            word  = {req_imm[31:12], req_rd, OP_AUIPC};
            legal = ~(|req_imm[11:0]);
         end
         default: legal = 1'b0;
      endcase
   end

   assign req_ready  = ~rst & ~addr_clr & (count_q != DEPTH_C);
   assign accept     = req_valid & req_ready;
   assign push       = accept & legal;
   assign imem_wen   = (count_q != '0);
   assign pop        = imem_wen & imem_wready;
   assign imem_waddr = addr_q;
   assign imem_wdata = imem_wen ? mem_q[rd_ptr_q] : 32'h0;
   assign enc_err    = enc_err_q;
   assign err_cnt    = err_cnt_q;
   assign wr_cnt     = wr_cnt_q;

   always_comb begin
      mem_d    = mem_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      wr_cnt_d = wr_cnt_q;
      if (push) mem_d[wr_ptr_q] = word;
      // A transfer during the flush cycle still reaches memory but is not counted.
      if (addr_clr) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         addr_d   = BASE;
         wr_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            addr_d   = addr_q + ADDR_WIDTH'(1);
            if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + (ADDR_WIDTH+1)'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
      enc_err_d = accept & ~legal;
      err_cnt_d = err_cnt_q;
      if (enc_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         addr_q    <= BASE;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
         enc_err_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         addr_q    <= addr_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
         enc_err_q <= enc_err_d;
      end
   end

   // Storage needs no reset: the output is masked whenever the buffer is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_inst_enc.sv
// Bench for inst_enc: vector table of encodings with a write-side scoreboard, plus
// hand-written sequences for backpressure, address wrap, flush and mid-stream reset.
module tb_inst_enc;
   localparam int AW = 2;
   localparam int WR_MAX = (1 << (AW + 1)) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          addr_clr = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_type = '0;
   logic [2:0]    req_funct3 = '0;
   logic          req_alt = 1'b0;
   logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0]   req_imm = '0;
   logic          imem_wen;
   logic          imem_wready = 1'b1;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          enc_err;
   logic [7:0]    err_cnt;
   logic [AW:0]   wr_cnt;

   inst_enc #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .addr_clr(addr_clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd), .req_rs1(req_rs1),
      .req_rs2(req_rs2), .req_imm(req_imm), .imem_wen(imem_wen), .imem_wready(imem_wready),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .enc_err(enc_err),
      .err_cnt(err_cnt), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  t;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        err;
      logic [31:0] word;
   } vec_t;

   vec_t        vecs[26];
   logic [31:0] exp_q[$];
   int cmp_n = 0, mis_n = 0;
   int exp_addr = 0, xfer_n = 0, err_exp = 0, err_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         mis_n++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Write-side scoreboard: every imem transfer must match the oldest expected word.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         if (imem_wen && imem_wready) begin
            if (exp_q.size() == 0) begin
               cmp_n++;
               mis_n++;
               $display("FAIL unexpected_write: got 0x%08h at %0d, expected no write",
                        imem_wdata, imem_waddr);
            end else begin
               e = exp_q.pop_front();
               check("wdata", imem_wdata, e);
               check("waddr", 32'(imem_waddr), 32'(exp_addr));
            end
            exp_addr = (exp_addr + 1) % (1 << AW);
            xfer_n++;
         end
         if (enc_err) err_seen++;
      end
   end

   task automatic send(input vec_t v);
      int k;
      req_type = v.t; req_funct3 = v.f3; req_alt = v.alt;
      req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
      req_valid = 1'b1;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (req_ready) break;
         @(posedge clk); #1;
      end
      if (k == 100) begin
         cmp_n++;
         mis_n++;
         $display("FAIL send_timeout: got req_ready=0 for 100 cycles, expected 1");
      end else if (!v.err) exp_q.push_back(v.word);
      else err_exp++;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!imem_wen) break;
      end
      check("drain_wen", 32'(imem_wen), 32'd0);
      check("drain_queue", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic clear();
      addr_clr = 1'b1;
      @(posedge clk); #1;
      addr_clr = 1'b0;
      exp_q.delete();
      exp_addr = 0;
      xfer_n = 0;
   endtask

   function automatic int wr_exp();
      return (xfer_n > WR_MAX) ? WR_MAX : xfer_n;
   endfunction

   initial begin
      //          type  f3    alt   rd     rs1    rs2    imm            err   word
      vecs[0]  = '{4'd1, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd5,         1'b0, 32'h00500093};
      vecs[1]  = '{4'd0, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  32'd0,         1'b0, 32'h002081B3};
      vecs[2]  = '{4'd0, 3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  32'd0,         1'b0, 32'h402081B3};
      vecs[3]  = '{4'd3, 3'd2, 1'b0, 5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h0020A423};
      vecs[4]  = '{4'd4, 3'd0, 1'b0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  1'b0, 32'hFE208EE3};
      vecs[5]  = '{4'd5, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 32'h0000006F};
      vecs[6]  = '{4'd7, 3'd0, 1'b0, 5'd5,  5'd0,  5'd0,  32'h12345000,  1'b0, 32'h123452B7};
      vecs[7]  = '{4'd2, 3'd2, 1'b0, 5'd4,  5'd2,  5'd0,  32'hFFFFFFFF,  1'b0, 32'hFFF12203};
      vecs[8]  = '{4'd1, 3'd5, 1'b1, 5'd6,  5'd7,  5'd0,  32'd3,         1'b0, 32'h4033D313};
      vecs[9]  = '{4'd6, 3'd3, 1'b0, 5'd1,  5'd5,  5'd0,  32'd16,        1'b0, 32'h010280E7};
      vecs[10] = '{4'd8, 3'd0, 1'b0, 5'd10, 5'd0,  5'd0,  32'hFFFFF000,  1'b0, 32'hFFFFF517};
      vecs[11] = '{4'd5, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd2048,      1'b0, 32'h001000EF};
      vecs[12] = '{4'd4, 3'd1, 1'b0, 5'd0,  5'd0,  5'd0,  32'd4094,      1'b0, 32'h7E001FE3};
      vecs[13] = '{4'd3, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFFF800,  1'b0, 32'h80000023};
      vecs[14] = '{4'd1, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd2048,      1'b1, 32'h0};
      vecs[15] = '{4'd4, 3'd0, 1'b0, 5'd0,  5'd1,  5'd2,  32'd3,         1'b1, 32'h0};
      vecs[16] = '{4'd12,3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'd0,         1'b1, 32'h0};
      vecs[17] = '{4'd1, 3'd1, 1'b1, 5'd1,  5'd1,  5'd0,  32'd3,         1'b1, 32'h0};
      vecs[18] = '{4'd0, 3'd1, 1'b1, 5'd1,  5'd1,  5'd1,  32'd0,         1'b1, 32'h0};
      vecs[19] = '{4'd2, 3'd3, 1'b0, 5'd1,  5'd1,  5'd0,  32'd0,         1'b1, 32'h0};
      vecs[20] = '{4'd3, 3'd3, 1'b0, 5'd0,  5'd1,  5'd2,  32'd0,         1'b1, 32'h0};
      vecs[21] = '{4'd5, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd1,         1'b1, 32'h0};
      vecs[22] = '{4'd7, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000123,  1'b1, 32'h0};
      vecs[23] = '{4'd4, 3'd2, 1'b0, 5'd0,  5'd1,  5'd2,  32'd4,         1'b1, 32'h0};
      vecs[24] = '{4'd1, 3'd1, 1'b0, 5'd1,  5'd1,  5'd0,  32'd32,        1'b1, 32'h0};
      vecs[25] = '{4'd5, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00100000,  1'b1, 32'h0};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_rst", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_wen", 32'(imem_wen), 32'd0);
      check("rst_waddr", 32'(imem_waddr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_enc_err", 32'(enc_err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      @(posedge clk); #1;

      // Legal and illegal encodings, one request at a time
      for (int i = 0; i < 26; i++) begin
         send(vecs[i]);
         @(negedge clk);
         if (i == 0) check("latency_wen", 32'(imem_wen), 32'd1);
         check("enc_err", 32'(enc_err), 32'(vecs[i].err));
         check("err_cnt", 32'(err_cnt), 32'(err_exp));
         @(posedge clk); #1;
         if (i == 13) begin
            drain();
            check("wr_cnt_sat", 32'(wr_cnt), 32'(wr_exp()));
         end
      end
      drain();
      check("err_pulses", 32'(err_seen), 32'(err_exp));
      check("err_cnt_total", 32'(err_cnt), 32'd12);
      check("wr_cnt_after_err", 32'(wr_cnt), 32'(wr_exp()));

      // Backpressure: fill the buffer, hold, then release with a fifth request
      clear();
      imem_wready = 1'b0;
      for (int i = 0; i < 4; i++) send(vecs[i]);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("full_ready", 32'(req_ready), 32'd0);
         check("hold_wen", 32'(imem_wen), 32'd1);
         check("hold_wdata", imem_wdata, exp_q[0]);
         check("hold_waddr", 32'(imem_waddr), 32'd0);
      end
      @(posedge clk); #1;
      imem_wready = 1'b1;
      send(vecs[4]);
      drain();
      check("wr_cnt_5", 32'(wr_cnt), 32'd5);
      for (int i = 5; i < 9; i++) send(vecs[i]);
      drain();
      check("wr_cnt_sat2", 32'(wr_cnt), 32'(WR_MAX));

      // Flush with words still buffered
      imem_wready = 1'b0;
      send(vecs[9]);
      send(vecs[10]);
      clear();
      @(negedge clk);
      check("clr_wen", 32'(imem_wen), 32'd0);
      check("clr_waddr", 32'(imem_waddr), 32'd0);
      check("clr_wr_cnt", 32'(wr_cnt), 32'd0);
      check("clr_err_cnt", 32'(err_cnt), 32'd12);
      check("clr_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      imem_wready = 1'b1;
      send(vecs[11]);
      drain();

      // Reset in the middle of a stream
      imem_wready = 1'b0;
      send(vecs[12]);
      send(vecs[13]);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_addr = 0;
      xfer_n = 0;
      err_exp = 0;
      @(negedge clk);
      check("mrst_wen", 32'(imem_wen), 32'd0);
      check("mrst_waddr", 32'(imem_waddr), 32'd0);
      check("mrst_err_cnt", 32'(err_cnt), 32'd0);
      check("mrst_wr_cnt", 32'(wr_cnt), 32'd0);
      @(posedge clk); #1;
      imem_wready = 1'b1;
      send(vecs[0]);
      drain();
      check("mrst_wr_cnt_1", 32'(wr_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
      $finish;
   end
endmodule
